// File: rtl/axil_cmd_master.sv
// AXI4-Lite single-outstanding command master: turns a cmd/rsp stream into AW/W/B or AR/R
// transactions, with an optional abort timeout for slaves that never answer.
module axil_cmd_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [2:0]  PROT       = 3'b000,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic [2:0]              m_axil_awprot,
  output logic                    m_axil_awvalid,
  input  logic                    m_axil_awready,
  output logic [DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                    m_axil_wvalid,
  input  logic                    m_axil_wready,
  input  logic [1:0]              m_axil_bresp,
  input  logic                    m_axil_bvalid,
  output logic                    m_axil_bready,
  output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic [2:0]              m_axil_arprot,
  output logic                    m_axil_arvalid,
  input  logic                    m_axil_arready,
  input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]              m_axil_rresp,
  input  logic                    m_axil_rvalid,
  output logic                    m_axil_rready
);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StResp} state_e;

  // Counter value seen in the last cycle before the count reaches TIMEOUT.
  localparam logic [31:0] TmoLast = 32'(TIMEOUT - 1);

  state_e                    state_q;
  logic                      awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                      aw_done_q, w_done_q, ar_done_q;
  logic [31:0]               tmo_cnt_q;
  logic [ADDR_WIDTH-1:0]     awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0]     wdata_q, rsp_rdata_q;
  logic [DATA_WIDTH/8-1:0]   wstrb_q;
  logic                      rsp_valid_q, rsp_timeout_q;
  logic [1:0]                rsp_resp_q;

  logic aw_hs, w_hs, ar_hs, aw_done, w_done, ar_done, b_acc, r_acc, tmo_hit;

  // Handshakes completing this cycle count as done, so combinational slaves finish in one cycle.
  assign aw_hs   = awvalid_q && m_axil_awready;
  assign w_hs    = wvalid_q && m_axil_wready;
  assign ar_hs   = arvalid_q && m_axil_arready;
  assign aw_done = aw_done_q || aw_hs;
  assign w_done  = w_done_q || w_hs;
  assign ar_done = ar_done_q || ar_hs;
  assign b_acc   = bready_q && m_axil_bvalid && aw_done && w_done;
  assign r_acc   = rready_q && m_axil_rvalid && ar_done;
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt_q == TmoLast);

  assign cmd_ready      = (state_q == StIdle) && !rst;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = PROT;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = PROT;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      ar_done_q     <= 1'b0;
      tmo_cnt_q     <= '0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            tmo_cnt_q <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
            if (cmd_write) begin
              awaddr_q  <= cmd_addr;
              wdata_q   <= cmd_wdata;
              wstrb_q   <= cmd_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              bready_q  <= 1'b1;
              state_q   <= StWr;
            end else begin
              araddr_q  <= cmd_addr;
              arvalid_q <= 1'b1;
              rready_q  <= 1'b1;
              state_q   <= StRd;
            end
          end
        end
        StWr: begin
          tmo_cnt_q <= tmo_cnt_q + 32'd1;
          aw_done_q <= aw_done;
          w_done_q  <= w_done;
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs) wvalid_q <= 1'b0;
          // A response in the same cycle as the timeout still completes normally.
          if (b_acc || tmo_hit) begin
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= b_acc ? m_axil_bresp : 2'b10;
            rsp_timeout_q <= !b_acc;
            state_q       <= StResp;
          end
        end
        StRd: begin
          tmo_cnt_q <= tmo_cnt_q + 32'd1;
          ar_done_q <= ar_done;
          if (ar_hs) arvalid_q <= 1'b0;
          if (r_acc || tmo_hit) begin
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= r_acc ? m_axil_rdata : '0;
            rsp_resp_q    <= r_acc ? m_axil_rresp : 2'b10;
            rsp_timeout_q <= !r_acc;
            state_q       <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: a configurable-latency AXI4-Lite RAM slave plus a transaction-level
// reference model predicting response, latency and per-channel valid durations.
module tb_axil_cmd_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;
  logic [1:0]  m_axil_bresp, m_axil_rresp;

  always #5 clk = ~clk;

  axil_cmd_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT(3'b000), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // ---------------- slave model ----------------
  int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic        b_early, r_early;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic [31:0] smem [256];
  int          aw_n, w_n, ar_n, b_n, r_n;
  logic        aw_got, w_got, ar_got;
  logic [31:0] lat_awaddr, lat_wdata, lat_araddr;
  logic [3:0]  lat_wstrb;
  logic        aw_hs, w_hs, ar_hs, aw_ok, w_ok, ar_ok, b_fire, r_fire;
  logic [31:0] wr_addr, wr_data, rd_addr;
  logic [3:0]  wr_strb;

  assign m_axil_awready = m_axil_awvalid && !aw_got && (aw_n >= aw_dly);
  assign m_axil_wready  = m_axil_wvalid && !w_got && (w_n >= w_dly);
  assign m_axil_arready = m_axil_arvalid && !ar_got && (ar_n >= ar_dly);
  assign aw_hs   = m_axil_awvalid && m_axil_awready;
  assign w_hs    = m_axil_wvalid && m_axil_wready;
  assign ar_hs   = m_axil_arvalid && m_axil_arready;
  assign aw_ok   = aw_got || aw_hs;
  assign w_ok    = w_got || w_hs;
  assign ar_ok   = ar_got || ar_hs;
  // Early modes raise valid as soon as the master is ready, before the address phase is done.
  assign m_axil_bvalid = b_early ? m_axil_bready : (aw_ok && w_ok && (b_n >= b_dly));
  assign m_axil_rvalid = r_early ? m_axil_rready : (ar_ok && (r_n >= r_dly));
  assign b_fire  = m_axil_bvalid && m_axil_bready && aw_ok && w_ok;
  assign r_fire  = m_axil_rvalid && m_axil_rready && ar_ok;
  assign m_axil_bresp = bresp_cfg;
  assign m_axil_rresp = rresp_cfg;
  assign wr_addr = aw_got ? lat_awaddr : m_axil_awaddr;
  assign wr_data = w_got ? lat_wdata : m_axil_wdata;
  assign wr_strb = w_got ? lat_wstrb : m_axil_wstrb;
  assign rd_addr = ar_got ? lat_araddr : m_axil_araddr;
  assign m_axil_rdata = smem[rd_addr[9:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) smem[i] <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_n <= 0; w_n <= 0; ar_n <= 0; b_n <= 0; r_n <= 0;
      lat_awaddr <= '0; lat_wdata <= '0; lat_wstrb <= '0; lat_araddr <= '0;
    end else begin
      if (m_axil_awvalid && !aw_got && !aw_hs) aw_n <= aw_n + 1;
      if (aw_hs) begin aw_got <= 1'b1; lat_awaddr <= m_axil_awaddr; end
      if (m_axil_wvalid && !w_got && !w_hs) w_n <= w_n + 1;
      if (w_hs) begin w_got <= 1'b1; lat_wdata <= m_axil_wdata; lat_wstrb <= m_axil_wstrb; end
      if (aw_ok && w_ok && !b_fire) b_n <= b_n + 1;
      if (b_fire) begin
        if (bresp_cfg == 2'b00) smem[wr_addr[9:2]] <= merge(smem[wr_addr[9:2]], wr_data, wr_strb);
        aw_got <= 1'b0; w_got <= 1'b0; aw_n <= 0; w_n <= 0; b_n <= 0;
      end
      if (m_axil_arvalid && !ar_got && !ar_hs) ar_n <= ar_n + 1;
      if (ar_hs) begin ar_got <= 1'b1; lat_araddr <= m_axil_araddr; end
      if (ar_ok && !r_fire) r_n <= r_n + 1;
      if (r_fire) begin ar_got <= 1'b0; ar_n <= 0; r_n <= 0; end
    end
  end

  // ---------------- monitor ----------------
  int awv_n = 0, wv_n = 0, arv_n = 0, rsph_n = 0, rspv_n = 0;
  always @(posedge clk) begin
    if (m_axil_awvalid) awv_n++;
    if (m_axil_wvalid) wv_n++;
    if (m_axil_arvalid) arv_n++;
    if (rsp_valid && rsp_ready) rsph_n++;
    if (rsp_valid) rspv_n++;
  end

  // ---------------- reference model and checking ----------------
  logic [31:0] ref_mem [256];
  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
  endtask

  task automatic set_slave(input int aw, input int w, input int b, input int ar, input int r,
                           input logic be, input logic re, input logic [1:0] br,
                           input logic [1:0] rr);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    b_early = be; r_early = re; bresp_cfg = br; rresp_cfg = rr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_ref();
    @(negedge clk);
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb, input int hold,
                         output logic [31:0] rdata_o);
    int          c, exp_lat, exp_aw, exp_w, exp_ar, lat, waitn;
    int          b_aw, b_w, b_ar, b_rsp;
    logic        exp_tmo;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata, s_rdata;
    logic [1:0]  s_resp;
    // Cycle after accept in which the response is taken, absent a timeout.
    if (wr) c = (b_early ? 0 : b_dly) + ((aw_dly > w_dly) ? aw_dly : w_dly) + 1;
    else    c = (r_early ? 0 : r_dly) + ar_dly + 1;
    exp_tmo = (c > TMO);
    exp_aw  = wr ? min2(aw_dly + 1, TMO) : 0;
    exp_w   = wr ? min2(w_dly + 1, TMO) : 0;
    exp_ar  = wr ? 0 : min2(ar_dly + 1, TMO);
    if (exp_tmo) begin
      exp_lat = TMO + 1; exp_resp = 2'b10; exp_rdata = '0;
    end else begin
      exp_lat   = c + 1;
      exp_resp  = wr ? bresp_cfg : rresp_cfg;
      exp_rdata = wr ? 32'h0 : ref_mem[addr[9:2]];
      if (wr && bresp_cfg == 2'b00) ref_mem[addr[9:2]] = merge(ref_mem[addr[9:2]], data, strb);
    end

    waitn = 0;
    while (!cmd_ready && waitn < 20) begin @(negedge clk); waitn++; end
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    b_aw = awv_n; b_w = wv_n; b_ar = arv_n; b_rsp = rsph_n;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_resp"}, rsp_resp, exp_resp);
    check({tag, "_timeout"}, rsp_timeout, exp_tmo);
    s_rdata = rsp_rdata; s_resp = rsp_resp;
    rdata_o = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, rsp_valid, 1'b1);
      check({tag, "_hold_rdata"}, rsp_rdata, s_rdata);
      check({tag, "_hold_resp"}, rsp_resp, s_resp);
      check({tag, "_hold_cmd_ready"}, cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, rsp_valid, 1'b0);
    check({tag, "_cmd_ready_after"}, cmd_ready, 1'b1);
    check({tag, "_awvalid_cycles"}, awv_n - b_aw, exp_aw);
    check({tag, "_wvalid_cycles"}, wv_n - b_w, exp_w);
    check({tag, "_arvalid_cycles"}, arv_n - b_ar, exp_ar);
    check({tag, "_rsp_count"}, rsph_n - b_rsp, 1);
  endtask

  initial begin
    logic [31:0] rd;
    int          base_rspv;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    set_slave(0, 0, 0, 0, 0, 1'b0, 1'b0, 2'b00, 2'b00);
    clear_ref();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, rsp_valid}, 4'b0);
    check("rst_readies", {m_axil_bready, m_axil_rready, rsp_timeout}, 3'b0);
    check("rst_addr_data", {m_axil_awaddr, m_axil_araddr}, 64'h0);
    check("rst_wdata_rdata", {m_axil_wdata, rsp_rdata}, 64'h0);
    check("rst_strb_resp", {m_axil_wstrb, rsp_resp}, 6'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1'b1);

    // Zero-wait RAM: write then read back.
    run_txn("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
    run_txn("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
    check("rd10_const", rd, 32'hDEADBEEF);
    run_txn("wr20a", 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd);
    run_txn("wr20b", 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, rd);
    run_txn("rd20", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
    check("rd20_const", rd, 32'h11BB33DD);

    // AW delayed three cycles, W immediate, B two cycles later with SLVERR.
    set_slave(3, 0, 2, 0, 0, 1'b0, 1'b0, 2'b10, 2'b00);
    run_txn("slverr", 1'b1, 32'h30, 32'h12345678, 4'hF, 0, rd);
    check("slverr_resp_const", dut.rsp_resp_q, 2'b10);
    // Early bvalid/rvalid must be ignored until the address phase completes.
    set_slave(2, 1, 0, 0, 0, 1'b1, 1'b0, 2'b00, 2'b00);
    run_txn("early_b", 1'b1, 32'h34, 32'hCAFEF00D, 4'hF, 0, rd);
    set_slave(0, 0, 0, 2, 0, 1'b0, 1'b1, 2'b00, 2'b00);
    run_txn("early_r", 1'b0, 32'h34, 32'h0, 4'h0, 0, rd);
    // Response held for five cycles.
    set_slave(0, 0, 0, 0, 0, 1'b0, 1'b0, 2'b00, 2'b00);
    run_txn("hold5", 1'b0, 32'h20, 32'h0, 4'h0, 5, rd);

    // Randomized traffic over a small address window so reads hit earlier writes.
    for (int n = 0; n < 24; n++) begin
      set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00,
                ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00);
      run_txn("rand", 1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) << 2, $urandom,
              4'($urandom_range(0, 15)), $urandom_range(0, 2), rd);
    end

    // Response in the cycle the count reaches TIMEOUT completes normally; one later aborts.
    set_slave(0, 0, 0, 7, 0, 1'b0, 1'b0, 2'b00, 2'b00);
    run_txn("tmo_edge", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
    set_slave(0, 0, 0, 1000, 0, 1'b0, 1'b0, 2'b00, 2'b00);
    run_txn("tmo_rd", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
    do_reset();
    set_slave(1000, 0, 0, 0, 0, 1'b1, 1'b0, 2'b00, 2'b00);
    run_txn("tmo_wr", 1'b1, 32'h10, 32'h55AA55AA, 4'hF, 1, rd);
    do_reset();

    // Reset one cycle after a write is accepted.
    set_slave(2, 2, 0, 0, 0, 1'b0, 1'b0, 2'b00, 2'b00);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h0BAD0BAD;
    cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rstmid_awvalid_before", m_axil_awvalid, 1'b1);
    base_rspv = rspv_n;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, rsp_valid}, 4'b0);
    check("rstmid_readies", {m_axil_bready, m_axil_rready}, 2'b0);
    check("rstmid_cmd_ready", cmd_ready, 1'b0);
    rst = 1'b0;
    clear_ref();
    @(negedge clk);
    check("rstmid_cmd_ready_after", cmd_ready, 1'b1);
    repeat (4) @(negedge clk);
    check("rstmid_no_rsp", rspv_n - base_rspv, 0);
    set_slave(0, 0, 0, 0, 0, 1'b0, 1'b0, 2'b00, 2'b00);
    run_txn("post_wr", 1'b1, 32'h40, 32'h600DF00D, 4'hF, 0, rd);
    run_txn("post_rd", 1'b0, 32'h40, 32'h0, 4'h0, 0, rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
